instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 25 ++
 rtl/pc_next_logic.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: PC-select encodings,
// fetch FSM states, status bit positions and an alignment helper.
package instruction_fetch_unit_pkg;

    // PC select encodings; any value with bit 1 set loads the branch target
    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;

    // Fetch handshake states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

    // Bit positions inside the 5-bit status word {V,C,N,Z_reg,alu_zero}
    localparam int STATUS_V     = 4;
    localparam int STATUS_Z_REG = 1;
    localparam int STATUS_Z_ALU = 0;

    // Instruction fetches must be word aligned
    function automatic logic is_word_aligned(input logic [63:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: hold, sequential increment, or branch target taken
// either PC-relative from the fetched instruction's address or from a_bus.
module pc_next_logic
    import instruction_fetch_unit_pkg::*;
(
    input  logic [1:0]  ps,
    input  logic        pc_sel,
    input  logic [63:0] pc,
    input  logic [63:0] fetch_pc,
    input  logic [63:0] constant,
    input  logic [63:0] a_bus,
    output logic [63:0] pc_next
);

    logic [63:0] branch_target;

    // Select the next PC; all arithmetic wraps modulo 2^64
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        pc_next       = pc;
        branch_target = pc_sel ? (fetch_pc + (constant << 2)) : a_bus;
        case (ps)
            PS_HOLD: pc_next = pc;
            PS_INC:  pc_next = pc + 64'd4;
            default: pc_next = branch_target;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, the instruction register and the
// status flags, and runs a two-state request/ready handshake to memory.
// While a fetch is pending (or after a misaligned fetch) it stalls the
// control unit and freezes PC and status.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        IL,
    input  logic [1:0]  PS,
    input  logic        PCsel,
    input  logic        SL,
    input  logic [63:0] constant,
    input  logic [63:0] a_bus,
    input  logic [3:0]  alu_flags,
    input  logic        alu_zero,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic [31:0] instruction,
    output logic [63:0] pc,
    output logic [63:0] fetch_pc,
    output logic [4:0]  status,
    output logic        stall,
    output logic        fault
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic        start_fetch;
    logic        fault_set;
    logic        fetch_done;
    logic [63:0] pc_next;
    logic [3:0]  flags_q;

    pc_next_logic u_pc_next_logic (
        .ps       (PS),
        .pc_sel   (PCsel),
        .pc       (pc),
        .fetch_pc (fetch_pc),
        .constant (constant),
        .a_bus    (a_bus),
        .pc_next  (pc_next)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: leave IDLE only for an aligned request, return on ready
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_fetch) state_next = ST_REQ;
            ST_REQ:  if (imem_ready)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: stall and the one-cycle fetch control strobes
    always_comb begin
        stall       = 1'b0;
        start_fetch = 1'b0;
        fault_set   = 1'b0;
        fetch_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A faulted unit stalls forever and never issues a request
                stall = IL | fault;
                if (IL && !fault) begin
                    if (is_word_aligned(pc)) start_fetch = 1'b1;
                    else                     fault_set   = 1'b1;
                end
            end
            ST_REQ: begin
                stall      = ~imem_ready;
                fetch_done = imem_ready;
            end
            default: begin
                stall = 1'b1;
            end
        endcase
    end

    // Memory request: address captured at launch and held until ready
    always_ff @(posedge clock) begin
        if (reset) begin
            imem_req  <= 1'b0;
            imem_addr <= 64'h0;
        end else if (start_fetch) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
        end else if (fetch_done) begin
            imem_req  <= 1'b0;
        end
    end

    // Instruction register and its address load only on a completed fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            instruction <= 32'h0;
            fetch_pc    <= 64'h0;
        end else if (fetch_done) begin
            instruction <= imem_rdata;
            fetch_pc    <= imem_addr;
        end
    end

    // Program counter advances only while the control unit is not stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            pc <= pc_next;
        end
    end

    // Registered ALU flags, loaded on SL when not stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= 4'h0;
        end else if (SL && !stall) begin
            flags_q <= alu_flags;
        end
    end

    // Sticky misaligned-fetch flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (fault_set) begin
            fault <= 1'b1;
        end
    end

    assign status[STATUS_V:STATUS_Z_REG] = flags_q;
    assign status[STATUS_Z_ALU]          = alu_zero;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized transaction stream compared against a behavioural model.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        IL;
    logic [1:0]  PS;
    logic        PCsel;
    logic        SL;
    logic [63:0] constant;
    logic [63:0] a_bus;
    logic [3:0]  alu_flags;
    logic        alu_zero;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic [63:0] fetch_pc;
    logic [4:0]  status;
    logic        stall;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit #(.RESET_PC(64'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .IL          (IL),
        .PS          (PS),
        .PCsel       (PCsel),
        .SL          (SL),
        .constant    (constant),
        .a_bus       (a_bus),
        .alu_flags   (alu_flags),
        .alu_zero    (alu_zero),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .instruction (instruction),
        .pc          (pc),
        .fetch_pc    (fetch_pc),
        .status      (status),
        .stall       (stall),
        .fault       (fault)
    );

    // Architectural next-PC rule, stated in plain arithmetic
    function automatic logic [63:0] model_next(input logic [1:0] ps, input logic sel,
                                               input logic [63:0] cur, input logic [63:0] fpc,
                                               input logic [63:0] k, input logic [63:0] a);
        if (ps == 2'd0) return cur;
        if (ps == 2'd1) return cur + 64'd4;
        return sel ? (fpc + k * 64'd4) : a;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        IL = 1'b0; PS = 2'b00; PCsel = 1'b0; SL = 1'b0;
        constant = 64'h0; a_bus = 64'h0; alu_flags = 4'h0; alu_zero = 1'b0;
        imem_rdata = 32'h0; imem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Complete fetch with a given number of not-ready cycles; PS/SL left as set by caller
    task automatic run_fetch(input logic [31:0] word, input int waits);
        IL = 1'b1; imem_ready = 1'b0;
        tick();
        for (int w = 0; w < waits; w++) tick();
        imem_ready = 1'b1; imem_rdata = word;
        tick();
        IL = 1'b0; imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; IL = 1'b1; PS = 2'b01; SL = 1'b1; alu_flags = 4'hF; a_bus = 64'h40;
        tick();
        PS = 2'b10;
        tick();
        n_checks++; if (pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 64'h0); end
        n_checks++; if (fetch_pc !== 64'h0) begin n_fail++; $display("FAIL reset_fetch_pc: got %h expected 0", fetch_pc); end
        n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h expected 0", instruction); end
        n_checks++; if (status !== 5'b0) begin n_fail++; $display("FAIL reset_status: got %b expected 00000", status); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 64'h0) begin n_fail++; $display("FAIL reset_req: got req=%b addr=%h expected 0/0", imem_req, imem_addr); end
        reset = 1'b0;
        idle_inputs();
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        // ready asserted while idle must be ignored
        IL = 1'b1; PS = 2'b01; imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL basic_stall_idle: got %b expected 1", stall); end
        tick();
        n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL basic_ir_idle: got %h expected 0", instruction); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin n_fail++; $display("FAIL basic_req: got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
        n_checks++; if (pc !== 64'h0) begin n_fail++; $display("FAIL basic_pc_hold: got %h expected 0", pc); end
        imem_rdata = 32'h8B020020;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL basic_stall_ready: got %b expected 0", stall); end
        tick();
        IL = 1'b0; PS = 2'b00; imem_ready = 1'b0;
        n_checks++; if (instruction !== 32'h8B020020) begin n_fail++; $display("FAIL basic_ir: got %h expected 8b020020", instruction); end
        n_checks++; if (fetch_pc !== 64'h0) begin n_fail++; $display("FAIL basic_fetch_pc: got %h expected 0", fetch_pc); end
        n_checks++; if (pc !== 64'h4) begin n_fail++; $display("FAIL basic_pc: got %h expected 4", pc); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %b expected 0", imem_req); end
    endtask

    task automatic test_wait_states();
        int stall_cycles = 0;
        IL = 1'b1; PS = 2'b01; imem_ready = 1'b0;
        #1;
        if (stall === 1'b1) stall_cycles++;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'h4 || pc !== 64'h4) begin
                n_fail++; $display("FAIL wait_hold[%0d]: got req=%b addr=%h pc=%h expected 1/4/4", i, imem_req, imem_addr, pc);
            end
            #1;
            if (stall === 1'b1) stall_cycles++;
            tick();
        end
        imem_ready = 1'b1; imem_rdata = 32'hF84003E1;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wait_stall_ready: got %b expected 0", stall); end
        tick();
        IL = 1'b0; PS = 2'b00; imem_ready = 1'b0;
        n_checks++; if (stall_cycles != 4) begin n_fail++; $display("FAIL wait_stall_count: got %0d expected 4", stall_cycles); end
        n_checks++; if (instruction !== 32'hF84003E1) begin n_fail++; $display("FAIL wait_ir: got %h expected f84003e1", instruction); end
        n_checks++; if (fetch_pc !== 64'h4) begin n_fail++; $display("FAIL wait_fetch_pc: got %h expected 4", fetch_pc); end
        n_checks++; if (pc !== 64'h8) begin n_fail++; $display("FAIL wait_pc: got %h expected 8", pc); end
    endtask

    task automatic test_branch();
        PS = 2'b10; PCsel = 1'b0; a_bus = 64'h100;
        tick();
        PS = 2'b00;
        n_checks++; if (pc !== 64'h100) begin n_fail++; $display("FAIL branch_abus_setup: got %h expected 100", pc); end
        run_fetch(32'h12345678, 1);
        n_checks++; if (fetch_pc !== 64'h100 || pc !== 64'h100) begin n_fail++; $display("FAIL branch_fetch: got fetch_pc=%h pc=%h expected 100/100", fetch_pc, pc); end
        PS = 2'b11; PCsel = 1'b1; constant = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        n_checks++; if (pc !== 64'hF8) begin n_fail++; $display("FAIL branch_rel_neg: got %h expected f8", pc); end
        PS = 2'b10; PCsel = 1'b0; a_bus = 64'h2000;
        tick();
        n_checks++; if (pc !== 64'h2000) begin n_fail++; $display("FAIL branch_abus: got %h expected 2000", pc); end
        idle_inputs();
    endtask

    task automatic test_wrap_and_fault();
        logic [31:0] ir_before;
        PS = 2'b10; PCsel = 1'b0; a_bus = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        PS = 2'b01;
        tick();
        n_checks++; if (pc !== 64'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", pc); end
        PS = 2'b10; a_bus = 64'h2002;
        tick();
        ir_before = instruction;
        PS = 2'b00; IL = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fault_stall_first: got %b expected 1", stall); end
        tick();
        n_checks++; if (fault !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL fault_set: got fault=%b req=%b expected 1/0", fault, imem_req); end
        IL = 1'b0; PS = 2'b01;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fault_stall_sticky: got %b expected 1", stall); end
        tick();
        IL = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hAAAA5555;
        tick();
        tick();
        n_checks++; if (pc !== 64'h2002) begin n_fail++; $display("FAIL fault_pc_frozen: got %h expected 2002", pc); end
        n_checks++; if (imem_req !== 1'b0 || instruction !== ir_before) begin n_fail++; $display("FAIL fault_no_fetch: got req=%b ir=%h expected 0/%h", imem_req, instruction, ir_before); end
        do_reset();
        n_checks++; if (fault !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL fault_cleared: got fault=%b stall=%b expected 0/0", fault, stall); end
    endtask

    task automatic test_status();
        do_reset();
        SL = 1'b1; alu_flags = 4'b1010; alu_zero = 1'b1;
        tick();
        n_checks++; if (status !== 5'b10101) begin n_fail++; $display("FAIL status_load: got %b expected 10101", status); end
        SL = 1'b0; alu_flags = 4'b0101;
        tick();
        alu_zero = 1'b0;
        #1;
        n_checks++; if (status !== 5'b10100) begin n_fail++; $display("FAIL status_hold: got %b expected 10100", status); end
        SL = 1'b1; alu_flags = 4'b0110; IL = 1'b1; imem_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (status[4:1] !== 4'b1010) begin n_fail++; $display("FAIL status_stalled: got %b expected 1010", status[4:1]); end
        imem_ready = 1'b1; imem_rdata = 32'h0;
        tick();
        idle_inputs();
        n_checks++; if (status[4:1] !== 4'b0110) begin n_fail++; $display("FAIL status_after_stall: got %b expected 0110", status[4:1]); end
    endtask

    task automatic test_reset_in_req();
        do_reset();
        IL = 1'b1; PS = 2'b01; imem_ready = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rreq_launch: got %b expected 1", imem_req); end
        reset = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b0 || pc !== 64'h0) begin n_fail++; $display("FAIL rreq_abandon: got req=%b pc=%h expected 0/0", imem_req, pc); end
        reset = 1'b0; IL = 1'b0; PS = 2'b00; imem_ready = 1'b1; imem_rdata = 32'hCAFEBABE;
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rreq_idle_stall: got %b expected 0", stall); end
        tick();
        tick();
        tick();
        n_checks++; if (instruction !== 32'h0 || fetch_pc !== 64'h0) begin n_fail++; $display("FAIL rreq_late_ready: got ir=%h fetch_pc=%h expected 0/0", instruction, fetch_pc); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [63:0] m_pc, m_fpc, nxt, k, a;
        logic [31:0] m_ir, word;
        logic [3:0]  m_flags, fl;
        logic [1:0]  ps;
        logic        sel, sl;
        int          waits;
        do_reset();
        m_pc = 64'h0; m_fpc = 64'h0; m_ir = 32'h0; m_flags = 4'h0;
        for (int t = 0; t < 60; t++) begin
            ps = 2'($urandom_range(0, 3)); sel = 1'($urandom_range(0, 1)); sl = 1'($urandom_range(0, 1));
            k = {$urandom, $urandom}; a = {$urandom, $urandom} & ~64'h3; fl = 4'($urandom_range(0, 15));
            PS = ps; PCsel = sel; SL = sl; constant = k; a_bus = a; alu_flags = fl;
            if ($urandom_range(0, 1) == 1) begin
                waits = $urandom_range(0, 3); word = $urandom;
                IL = 1'b1; imem_ready = 1'b0;
                #1;
                n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rnd_stall_launch[%0d]: got %b expected 1", t, stall); end
                tick();
                for (int w = 0; w < waits; w++) begin
                    n_checks++;
                    if (imem_addr !== m_pc || pc !== m_pc || stall !== 1'b1) begin
                        n_fail++; $display("FAIL rnd_wait[%0d]: got addr=%h pc=%h stall=%b expected %h/%h/1", t, imem_addr, pc, stall, m_pc, m_pc);
                    end
                    tick();
                end
                imem_ready = 1'b1; imem_rdata = word;
                #1;
                n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rnd_stall_done[%0d]: got %b expected 0", t, stall); end
                tick();
                nxt = model_next(ps, sel, m_pc, m_fpc, k, a);
                m_fpc = m_pc; m_pc = nxt; m_ir = word;
                if (sl) m_flags = fl;
                IL = 1'b0; imem_ready = 1'b0;
            end else begin
                imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
                #1;
                n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rnd_stall_plain[%0d]: got %b expected 0", t, stall); end
                tick();
                m_pc = model_next(ps, sel, m_pc, m_fpc, k, a);
                if (sl) m_flags = fl;
                imem_ready = 1'b0;
            end
            n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", t, pc, m_pc); end
            n_checks++; if (fetch_pc !== m_fpc) begin n_fail++; $display("FAIL rnd_fetch_pc[%0d]: got %h expected %h", t, fetch_pc, m_fpc); end
            n_checks++; if (instruction !== m_ir) begin n_fail++; $display("FAIL rnd_ir[%0d]: got %h expected %h", t, instruction, m_ir); end
            n_checks++; if (status[4:1] !== m_flags) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b expected %b", t, status[4:1], m_flags); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_idle[%0d]: got %b expected 0", t, imem_req); end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_branch();
        test_wrap_and_fault();
        test_status();
        test_reset_in_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
